stage_memory_access: RTL and testbench

Pipeline stage after execution. It consumes the execution stage's ALU result, rt operand, destination register and control signals. It performs byte, halfword and word loads and stores against an internal data memory, then registers the MEM/WB outputs for the writeback stage. A single-step enable lets the debug unit freeze the stage.

---
 rtl/stage_memory_access_pkg.sv | 43 ++++
 rtl/stage_memory_access_if.sv | 53 +++++
 rtl/stage_memory_access_data_memory.sv | 33 +++
 rtl/stage_memory_access.sv | 108 ++++++++++
 tb/tb_stage_memory_access.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/stage_memory_access_pkg.sv
// Shared constants for the MEM stage: opcodes, widths, access-size and byte-enable encodings.
package stage_memory_access_pkg;

  localparam int NB_DATA     = 32;
  localparam int NB_MEM_ADDR = 10;
  localparam int NB_REG      = 5;
  localparam int NB_OP       = 6;

  localparam logic [NB_OP-1:0] OP_LB  = 6'b100000;
  localparam logic [NB_OP-1:0] OP_LBU = 6'b100100;
  localparam logic [NB_OP-1:0] OP_LH  = 6'b100001;
  localparam logic [NB_OP-1:0] OP_LHU = 6'b100101;
  localparam logic [NB_OP-1:0] OP_LW  = 6'b100011;
  localparam logic [NB_OP-1:0] OP_SB  = 6'b101000;
  localparam logic [NB_OP-1:0] OP_SH  = 6'b101001;
  localparam logic [NB_OP-1:0] OP_SW  = 6'b101011;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  // Anything not recognised as byte/half falls back to a word access.
  function automatic acc_size_e op_size(input logic [NB_OP-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input acc_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return BE_B0 << lane;
      SZ_HALF: return lane[1] ? BE_HHI : BE_HLO;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/stage_memory_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage; MEM_DEBUG_PORT_EN adds the memory dump port.
interface stage_memory_access_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 10,
  parameter int NB_REG      = 5,
  parameter int NB_OP       = 6
);
  logic               i_enable;
  logic [NB_DATA-1:0] i_ALU_res;
  logic [NB_DATA-1:0] i_rt_reg;
  logic [NB_REG-1:0]  i_addr_reg_dst;
  logic [NB_OP-1:0]   i_op;
  logic               is_MemRead;
  logic               is_MemWrite;
  logic               is_MemtoReg;
  logic               is_RegWrite;
  logic [NB_DATA-1:0] o_read_data;
  logic [NB_DATA-1:0] o_ALU_res;
  logic [NB_REG-1:0]  o_addr_reg_dst;
  logic               os_RegWrite;
  logic               os_MemtoReg;
  logic               os_addr_error;
`ifdef MEM_DEBUG_PORT_EN
  logic [NB_MEM_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0]     o_dbg_data;

  modport master (
    output i_enable, i_ALU_res, i_rt_reg, i_addr_reg_dst, i_op,
           is_MemRead, is_MemWrite, is_MemtoReg, is_RegWrite, i_dbg_addr,
    input  o_read_data, o_ALU_res, o_addr_reg_dst, os_RegWrite, os_MemtoReg,
           os_addr_error, o_dbg_data
  );
  modport slave (
    input  i_enable, i_ALU_res, i_rt_reg, i_addr_reg_dst, i_op,
           is_MemRead, is_MemWrite, is_MemtoReg, is_RegWrite, i_dbg_addr,
    output o_read_data, o_ALU_res, o_addr_reg_dst, os_RegWrite, os_MemtoReg,
           os_addr_error, o_dbg_data
  );
`else
  modport master (
    output i_enable, i_ALU_res, i_rt_reg, i_addr_reg_dst, i_op,
           is_MemRead, is_MemWrite, is_MemtoReg, is_RegWrite,
    input  o_read_data, o_ALU_res, o_addr_reg_dst, os_RegWrite, os_MemtoReg,
           os_addr_error
  );
  modport slave (
    input  i_enable, i_ALU_res, i_rt_reg, i_addr_reg_dst, i_op,
           is_MemRead, is_MemWrite, is_MemtoReg, is_RegWrite,
    output o_read_data, o_ALU_res, o_addr_reg_dst, os_RegWrite, os_MemtoReg,
           os_addr_error
  );
`endif
endinterface

// File: rtl/stage_memory_access_data_memory.sv
// Word-wide data memory: byte-enable synchronous write, asynchronous read.
// MEM_DEBUG_PORT_EN adds a second asynchronous read port for memory dumps.
module data_memory #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 10
) (
  input  logic                   clk,
  input  logic [NB_MEM_ADDR-1:0] addr,
  input  logic [3:0]             we_be,
  input  logic [NB_DATA-1:0]     wdata,
  output logic [NB_DATA-1:0]     rdata
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_MEM_ADDR-1:0] dbg_addr,
  output logic [NB_DATA-1:0]     dbg_data
`endif
);

  // Contents are intentionally not reset.
  logic [NB_DATA-1:0] mem_q [0:(1<<NB_MEM_ADDR)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we_be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign rdata = mem_q[addr];

`ifdef MEM_DEBUG_PORT_EN
  assign dbg_data = mem_q[dbg_addr];
`endif

endmodule

// File: rtl/stage_memory_access.sv
// MEM pipeline stage: aligned byte/half/word loads and stores, registered MEM/WB outputs.
// Optional MEM_DEBUG_PORT_EN exposes an asynchronous debug read of the data memory.
module stage_memory_access #(
  parameter int NB_DATA     = stage_memory_access_pkg::NB_DATA,
  parameter int NB_MEM_ADDR = stage_memory_access_pkg::NB_MEM_ADDR,
  parameter int NB_REG      = stage_memory_access_pkg::NB_REG,
  parameter int NB_OP       = stage_memory_access_pkg::NB_OP
) (
  input  logic                  clk,
  input  logic                  rst,
  stage_memory_access_if.slave  bus
);
  import stage_memory_access_pkg::*;

  logic [NB_OP-1:0]       op;
  logic [NB_MEM_ADDR-1:0] word_idx;
  logic [1:0]             lane;
  acc_size_e              size;
  logic                   signed_ld, misaligned;
  logic [3:0]             be;
  logic [NB_DATA-1:0]     wdata, rd_word, shifted, ld_data;

  logic [NB_DATA-1:0] read_data_d, read_data_q;
  logic [NB_DATA-1:0] alu_res_d, alu_res_q;
  logic [NB_REG-1:0]  addr_reg_dst_d, addr_reg_dst_q;
  logic               reg_write_d, reg_write_q;
  logic               mem_to_reg_d, mem_to_reg_q;
  logic               addr_error_d, addr_error_q;

  always_comb begin
    op        = bus.i_op;
    word_idx  = bus.i_ALU_res[NB_MEM_ADDR+1:2];
    lane      = bus.i_ALU_res[1:0];
    size      = op_size(op);
    signed_ld = (op == OP_LB) || (op == OP_LH);
    misaligned = (bus.is_MemRead || bus.is_MemWrite) &&
                 (((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'd0)));
    // rst gating drops a store coinciding with reset.
    be = (bus.i_enable && rst && bus.is_MemWrite && !misaligned) ? byte_en(size, lane) : BE_NONE;
    case (size)
      SZ_BYTE: wdata = {(NB_DATA/8){bus.i_rt_reg[7:0]}};
      SZ_HALF: wdata = {(NB_DATA/16){bus.i_rt_reg[15:0]}};
      default: wdata = bus.i_rt_reg;
    endcase
    shifted = rd_word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: ld_data = {{(NB_DATA-8){shifted[7] & signed_ld}}, shifted[7:0]};
      SZ_HALF: ld_data = {{(NB_DATA-16){shifted[15] & signed_ld}}, shifted[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    read_data_d    = read_data_q;
    alu_res_d      = alu_res_q;
    addr_reg_dst_d = addr_reg_dst_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    addr_error_d   = addr_error_q;
    if (bus.i_enable) begin
      read_data_d    = (bus.is_MemRead && !misaligned) ? ld_data : '0;
      alu_res_d      = bus.i_ALU_res;
      addr_reg_dst_d = bus.i_addr_reg_dst;
      reg_write_d    = bus.is_RegWrite;
      mem_to_reg_d   = bus.is_MemtoReg;
      addr_error_d   = addr_error_q | misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q    <= '0;
      alu_res_q      <= '0;
      addr_reg_dst_q <= '0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      addr_error_q   <= 1'b0;
    end else begin
      read_data_q    <= read_data_d;
      alu_res_q      <= alu_res_d;
      addr_reg_dst_q <= addr_reg_dst_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      addr_error_q   <= addr_error_d;
    end
  end

  data_memory #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR)) u_dmem (
    .clk      (clk),
    .addr     (word_idx),
    .we_be    (be),
    .wdata    (wdata),
    .rdata    (rd_word)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .dbg_addr (bus.i_dbg_addr),
    .dbg_data (bus.o_dbg_data)
`endif
  );

  assign bus.o_read_data    = read_data_q;
  assign bus.o_ALU_res      = alu_res_q;
  assign bus.o_addr_reg_dst = addr_reg_dst_q;
  assign bus.os_RegWrite    = reg_write_q;
  assign bus.os_MemtoReg    = mem_to_reg_q;
  assign bus.os_addr_error  = addr_error_q;

endmodule

// File: tb/tb_stage_memory_access.sv
// Directed bench for stage_memory_access; debug-port checks run when MEM_DEBUG_PORT_EN is defined.
module tb_stage_memory_access;
  import stage_memory_access_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   chk = 0;
  int   pass = 0;

  always #5 clk = ~clk;

  stage_memory_access_if bus ();

  stage_memory_access dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic drive(input logic en, input logic rd, input logic wr, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst,
                       input logic m2r, input logic rw);
    bus.i_enable       = en;
    bus.is_MemRead     = rd;
    bus.is_MemWrite    = wr;
    bus.i_op           = op;
    bus.i_ALU_res      = addr;
    bus.i_rt_reg       = data;
    bus.i_addr_reg_dst = dst;
    bus.is_MemtoReg    = m2r;
    bus.is_RegWrite    = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef MEM_DEBUG_PORT_EN
    bus.i_dbg_addr = '0;
`endif
    rst = 1'b0;
    #100;
    chk++; if (bus.o_read_data !== 32'h0) $display("FAIL rst_read_data: got %h want %h", bus.o_read_data, 32'h0); else pass++;
    chk++; if (bus.o_ALU_res !== 32'h0) $display("FAIL rst_alu_res: got %h want %h", bus.o_ALU_res, 32'h0); else pass++;
    chk++; if (bus.os_addr_error !== 1'b0) $display("FAIL rst_addr_error: got %b want 0", bus.os_addr_error); else pass++;
    @(negedge clk) rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk++; if ({bus.o_read_data, bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite, bus.os_MemtoReg, bus.os_addr_error} !== 72'h0)
      $display("FAIL post_rst_outputs: got %h %h %h %b %b %b want all 0", bus.o_read_data, bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite, bus.os_MemtoReg, bus.os_addr_error);
    else pass++;
  endtask

  task automatic test_loads();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h10, 32'h8000A5F0, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 5'd9, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h8000A5F0) $display("FAIL lw_10: got %h want %h", bus.o_read_data, 32'h8000A5F0); else pass++;
    chk++; if ({bus.o_addr_reg_dst, bus.os_MemtoReg, bus.os_RegWrite} !== {5'd9, 1'b1, 1'b1})
      $display("FAIL lw_ctrl: got %0d %b %b want 9 1 1", bus.o_addr_reg_dst, bus.os_MemtoReg, bus.os_RegWrite); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LB, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'hFFFFFFF0) $display("FAIL lb_10: got %h want %h", bus.o_read_data, 32'hFFFFFFF0); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LBU, 32'h13, 32'h0, 5'd1, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h00000080) $display("FAIL lbu_13: got %h want %h", bus.o_read_data, 32'h00000080); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LH, 32'h12, 32'h0, 5'd1, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'hFFFF8000) $display("FAIL lh_12: got %h want %h", bus.o_read_data, 32'hFFFF8000); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LHU, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h0000A5F0) $display("FAIL lhu_10: got %h want %h", bus.o_read_data, 32'h0000A5F0); else pass++;
  endtask

  task automatic test_sub_word_stores();
    drive(1'b1, 1'b0, 1'b1, OP_SB, 32'h11, 32'hFFFFFF12, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 5'd2, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h800012F0) $display("FAIL sb_11: got %h want %h", bus.o_read_data, 32'h800012F0); else pass++;
    drive(1'b1, 1'b0, 1'b1, OP_SH, 32'h12, 32'hABCD7777, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 5'd2, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h777712F0) $display("FAIL sh_12: got %h want %h", bus.o_read_data, 32'h777712F0); else pass++;
    // Upper address bits are ignored: 0x1010 aliases byte 0x10.
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h1010, 32'h0, 5'd2, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h777712F0) $display("FAIL wrap_1010: got %h want %h", bus.o_read_data, 32'h777712F0); else pass++;
    chk++; if (bus.o_ALU_res !== 32'h1010) $display("FAIL wrap_alu: got %h want %h", bus.o_ALU_res, 32'h1010); else pass++;
    drive(1'b1, 1'b1, 1'b0, 6'b000000, 32'h10, 32'h0, 5'd2, 1'b1, 1'b1); tick();
    chk++; if (bus.o_read_data !== 32'h777712F0) $display("FAIL unknown_op_word: got %h want %h", bus.o_read_data, 32'h777712F0); else pass++;
  endtask

  task automatic test_rw_conflict();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h50, 32'hAAAA0000, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, OP_SW, 32'h50, 32'h12345678, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'hAAAA0000) $display("FAIL conflict_old_data: got %h want %h", bus.o_read_data, 32'hAAAA0000); else pass++;
    chk++; if (bus.os_addr_error !== 1'b0) $display("FAIL conflict_no_err: got %b want 0", bus.os_addr_error); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h50, 32'h0, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'h12345678) $display("FAIL conflict_new_data: got %h want %h", bus.o_read_data, 32'h12345678); else pass++;
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h20, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h21, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.os_addr_error !== 1'b1) $display("FAIL sw_21_err: got %b want 1", bus.os_addr_error); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'hCAFEF00D) $display("FAIL sw_21_suppressed: got %h want %h", bus.o_read_data, 32'hCAFEF00D); else pass++;
    chk++; if (bus.os_addr_error !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.os_addr_error); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LH, 32'h21, 32'h0, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'h0) $display("FAIL lh_21_zero: got %h want %h", bus.o_read_data, 32'h0); else pass++;
    rst = 1'b0;
    #1;
    chk++; if (bus.os_addr_error !== 1'b0) $display("FAIL err_cleared_by_rst: got %b want 0", bus.os_addr_error); else pass++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_enable_hold();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h30, 32'h01020304, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1, OP_SW, 32'h30, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'h777712F0) $display("FAIL hold_read_data: got %h want %h", bus.o_read_data, 32'h777712F0); else pass++;
    drive(1'b0, 1'b1, 1'b0, OP_LB, 32'h31, 32'h5, 5'd12, 1'b0, 1'b0); tick();
    chk++; if ({bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite} !== {32'h10, 5'd7, 1'b1})
      $display("FAIL hold_ctrl: got %h %0d %b want 00000010 7 1", bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite); else pass++;
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h30, 32'h0, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'h01020304) $display("FAIL disabled_sw_dropped: got %h want %h", bus.o_read_data, 32'h01020304); else pass++;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h3, 32'h0, 5'd6, 1'b0, 1'b1); tick();
    chk++; if ({bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite, bus.o_read_data} !== {32'h3, 5'd6, 1'b1, 32'h0})
      $display("FAIL non_mem_op: got %h %0d %b %h want 00000003 6 1 00000000", bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite, bus.o_read_data); else pass++;
  endtask

  task automatic test_reset_store();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h40, 32'h55AA55AA, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, OP_SW, 32'h40, 32'h00000001, 5'd4, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    chk++; if (bus.o_ALU_res !== 32'h0) $display("FAIL async_rst_alu: got %h want %h", bus.o_ALU_res, 32'h0); else pass++;
    tick();
    chk++; if ({bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite} !== 38'h0)
      $display("FAIL rst_store_outputs: got %h %0d %b want 0 0 0", bus.o_ALU_res, bus.o_addr_reg_dst, bus.os_RegWrite); else pass++;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, OP_LW, 32'h40, 32'h0, 5'd0, 1'b0, 1'b0); tick();
    chk++; if (bus.o_read_data !== 32'h55AA55AA) $display("FAIL rst_store_discarded: got %h want %h", bus.o_read_data, 32'h55AA55AA); else pass++;
`ifdef MEM_DEBUG_PORT_EN
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.i_dbg_addr = 10'h10;
    #1;
    chk++; if (bus.o_dbg_data !== 32'h55AA55AA) $display("FAIL dbg_read_40: got %h want %h", bus.o_dbg_data, 32'h55AA55AA); else pass++;
    bus.i_dbg_addr = 10'h4;
    #1;
    chk++; if (bus.o_dbg_data !== 32'h777712F0) $display("FAIL dbg_read_10: got %h want %h", bus.o_dbg_data, 32'h777712F0); else pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_word_stores();
    test_rw_conflict();
    test_misaligned();
    test_enable_hold();
    test_reset_store();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
